uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver: the receive-side counterpart of the UART transmitter. It oversamples the serial line RX_IN at Prescale ticks per bit and recovers frames of 1 start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and 1 stop bit. Each bit value is the majority vote of three mid-bit samples. Good frames are delivered on P_DATA with a one-cycle data_valid strobe; bad frames raise one-cycle par_err / stp_err strobes.

## Interface
- DATA_WIDTH, 8, data bits per frame
- CLK  in  1  oversampling clock (Prescale × bit rate)
- RST  in  1  reset, asynchronous, active-low
- RX_IN  in  1  serial line, idle high, asynchronous to CLK
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- Prescale  in  6  ticks per bit; legal values 8, 16, 32 only
- P_DATA  out  DATA_WIDTH  received data, held until the next good frame
- data_valid  out  1  one-cycle strobe, P_DATA updated
- par_err  out  1  one-cycle strobe, parity mismatch
- stp_err  out  1  one-cycle strobe, stop bit sampled 0

## Operation
- Reset: all outputs 0, FSM in IDLE, counters 0, synchronizer flops 1.
- RX_IN passes through a 2-flop synchronizer. All references to "line" below mean the synchronizer output.
- Tick counter runs 0..Prescale-1 within each bit. Bit counter counts data bits.
- Sampling: the line is sampled at ticks P/2-1, P/2 and P/2+1, where P = Prescale. The bit value is the majority of the three samples and is valid at tick P/2+2.
- PAR_EN, PAR_TYP and Prescale are latched on leaving IDLE. Changes mid-frame have no effect.
- FSM states and transitions:
  - IDLE: line = 0 → START, tick = 0.
  - START: at tick P-1 → DATA if the voted start bit is 0. If it is 1 (glitch) → IDLE, with no strobe.
  - DATA: each voted bit is shifted in LSB first. After bit DATA_WIDTH-1 ends at tick P-1 → PARITY if PAR_EN, else STOP.
  - PARITY: voted bit is compared with the expected value. Expected = XOR(data) for even, ~XOR(data) for odd. At tick P-1 → STOP.
  - STOP: at tick P/2+2 the voted stop bit is evaluated → IDLE.
- Results, issued on the cycle after the STOP evaluation:
  - If stop = 1 and parity is good (or disabled): P_DATA ← shift register and data_valid = 1.
  - If stop = 0: stp_err = 1.
  - If parity is bad: par_err = 1.
  - Both errors may pulse together. On any error, P_DATA is unchanged and data_valid = 0.
- Returning to IDLE at mid-stop bit lets a following start bit, arriving up to P/2-3 ticks early, be caught. Back-to-back frames need no idle gap.
- If the line is 0 in IDLE right after a stop error (break condition), a new START is entered. A continuous break is reported as repeated stp_err, one per frame time.

## Timing
- Synchronizer adds 2 cycles.
- Strobe latency: the strobe occurs 2 + (1 + DATA_WIDTH + PAR_EN)·P + P/2 + 3 cycles after the RX_IN falling edge.
  - Example: P = 8, no parity: 2 + 72 + 4 + 3 = 81 cycles.
- Strobes are exactly 1 cycle wide and never overlap with data_valid.
- Reset asserted mid-frame: outputs clear immediately and asynchronously, and the frame is discarded. After release the FSM waits in IDLE for a line = 0.

## Structure
- Package uart_rx_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the legal prescale constants 8/16/32;
  - the default DATA_WIDTH.
- Sub-module uart_rx_sampler holds the tick counter, the three-sample capture and the majority vote. Its outputs are tick == P-1, the voted bit, and a vote-valid flag at tick P/2+2.
- The top level holds the synchronizer, FSM, bit counter, shift register, parity check and output registers.

## Test plan
- P = 8, PAR_EN = 1, even, frame 0xA5 (parity 0), stop 1 → P_DATA = 0xA5 with a data_valid pulse at cycle 89 after the falling edge; no error strobes.
- P = 16, PAR_EN = 1, odd, 0x3C sent with parity 1 (correct value is 1 for odd) → data_valid. Resend with parity 0 → par_err pulse only, P_DATA stays 0x3C.
- P = 32, PAR_EN = 0, 0x00 with stop bit 0 → stp_err pulse, data_valid = 0. A following good 0x7E frame → P_DATA = 0x7E.
- Glitch: RX_IN low for 3 cycles at P = 16 → FSM returns to IDLE at tick 15, no strobes. A subsequent valid 0x55 is received correctly.
- Noise: one sample inverted in the middle of each data bit of 0x96 at P = 8 → majority vote still yields 0x96.
- Back-to-back 0x11, 0x22, 0x33 at P = 8 with no idle gap, then RST pulsed in the middle of a 4th frame → three data_valid strobes, all outputs 0 after reset, the next frame 0x44 is received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Holds the FSM state encoding, the latched frame configuration and the majority vote.
package uart_rx_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   typedef struct packed {
      logic       par_en;
      logic       par_typ;
      logic [5:0] prescale;
   } cfg_t;

   function automatic logic prescale_legal(input logic [5:0] p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and frame configuration in, recovered data and strobes out.
interface uart_rx_if
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

   logic                  RX_IN;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic [5:0]            Prescale;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;

   modport master (
      output RX_IN, PAR_EN, PAR_TYP, Prescale,
      input  P_DATA, data_valid, par_err, stp_err
   );

   modport slave (
      input  RX_IN, PAR_EN, PAR_TYP, Prescale,
      output P_DATA, data_valid, par_err, stp_err
   );

endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit tick counter with three mid-bit samples and a majority vote.
// The vote stays stable from tick P/2+2 until the next bit's first sample.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       enable,
   input  logic [5:0] prescale,
   input  logic       line,
   output logic       last_tick,
   output logic       vote,
   output logic       vote_valid
);

   logic [5:0] tick_q, tick_d;
   logic [2:0] samp_q, samp_d;
   logic [2:0] samp_hit;
   logic [5:0] half;

   assign half = prescale >> 1;

   for (genvar gi = 0; gi < 3; gi++) begin : g_samp
      assign samp_hit[gi] = enable && (tick_q == half - 6'd1 + 6'(gi));
   end

   assign last_tick  = enable && (tick_q == prescale - 6'd1);
   assign vote_valid = enable && (tick_q == half + 6'd2);
   assign vote       = majority3(samp_q);

   always_comb begin
      tick_d = '0;
      if (enable && !last_tick) begin
         tick_d = tick_q + 6'd1;
      end
      samp_d = (samp_hit & {3{line}}) | (~samp_hit & samp_q);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tick_q <= '0;
         samp_q <= 3'b111;
      end else begin
         tick_q <= tick_d;
         samp_q <= samp_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: line synchronizer, frame FSM, data shift register, parity/stop checks.
// Results are registered one cycle after the mid-stop evaluation.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic     CLK,
   input  logic     RST,
   uart_rx_if.slave bus
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   state_e                state_q, state_d;
   cfg_t                  cfg_q, cfg_d;
   logic [1:0]            sync_q, sync_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;

   logic line;
   logic sampler_en;
   logic last_tick;
   logic vote;
   logic vote_valid;
   logic par_ok;

   assign sync_d     = {sync_q[0], bus.RX_IN};
   assign line       = sync_q[1];
   assign sampler_en = (state_q != IDLE);

   uart_rx_sampler u_sampler (
      .CLK        (CLK),
      .RST        (RST),
      .enable     (sampler_en),
      .prescale   (cfg_q.prescale),
      .line       (line),
      .last_tick  (last_tick),
      .vote       (vote),
      .vote_valid (vote_valid)
   );

   assign par_ok = !cfg_q.par_en || (par_bit_q == ((^shift_q) ^ cfg_q.par_typ));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!line) state_d = START;
         START:   if (last_tick) state_d = vote ? IDLE : DATA;
         DATA:    if (last_tick && (bit_cnt_q == LAST_BIT)) state_d = cfg_q.par_en ? PARITY : STOP;
         PARITY:  if (last_tick) state_d = STOP;
         STOP:    if (vote_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cfg_d        = cfg_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      p_data_d     = p_data_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stp_err_d    = 1'b0;
      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            // Illegal prescale values fall back to 16 instead of running malformed bit timing.
            if (!line) begin
               cfg_d.par_en   = bus.PAR_EN;
               cfg_d.par_typ  = bus.PAR_TYP;
               cfg_d.prescale = prescale_legal(bus.Prescale) ? bus.Prescale : PRESCALE_16;
            end
         end
         DATA: begin
            if (vote_valid) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
            if (last_tick)  bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
         PARITY: begin
            if (vote_valid) par_bit_d = vote;
         end
         STOP: begin
            if (vote_valid) begin
               stp_err_d = !vote;
               par_err_d = !par_ok;
               if (vote && par_ok) begin
                  p_data_d     = shift_q;
                  data_valid_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cfg_q        <= '0;
         sync_q       <= 2'b11;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         par_bit_q    <= 1'b0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         cfg_q        <= cfg_d;
         sync_q       <= sync_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         p_data_q     <= p_data_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stp_err_q    <= stp_err_d;
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.data_valid = data_valid_q;
   assign bus.par_err    = par_err_q;
   assign bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, hand-written corner
// sequences and random frames, all checked against a frame-level reference model.
module tb_uart_rx;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_if #(.DATA_WIDTH(8)) bus ();

   uart_rx #(.DATA_WIDTH(8)) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   typedef struct {
      int         p;
      bit         pe;
      bit         pt;
      logic [7:0] d;
      bit         flip;
      bit         stop;
      bit         noise;
      bit         scr;
      int         gap;
      bit         dv;
      bit         perr;
      bit         serr;
      logic [7:0] pdata;
      int         lat;
   } vec_t;

   typedef struct {
      int         cyc;
      bit         dv;
      bit         pe;
      bit         se;
      logic [7:0] pdata;
   } ev_t;

   int         checks     = 0;
   int         failures   = 0;
   int         cyc        = 0;
   int         strobe_cnt = 0;
   logic [7:0] last_good  = 8'h00;
   ev_t        exp_q[$];
   vec_t       vecs[8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Parity bit that a correct transmitter sends: even makes total ones even, odd makes it odd.
   function automatic bit par_bit_for(input logic [7:0] d, input bit odd);
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(d[i]);
      return odd ? (n % 2 == 0) : (n % 2 == 1);
   endfunction

   function automatic vec_t mk(input int p, input bit pe, input bit pt, input logic [7:0] d,
                               input bit flip, input bit stop, input bit noise, input bit scr,
                               input int gap);
      vec_t v;
      bit   good;
      v.p = p; v.pe = pe; v.pt = pt; v.d = d; v.flip = flip; v.stop = stop;
      v.noise = noise; v.scr = scr; v.gap = gap;
      good    = par_bit_for(d, pt);
      v.perr  = pe && ((good ^ flip) != good);
      v.serr  = !stop;
      v.dv    = stop && !v.perr;
      v.pdata = v.dv ? d : last_good;
      v.lat   = 2 + (9 + (pe ? 1 : 0)) * p + p / 2 + 3;
      return v;
   endfunction

   task automatic drive(input logic b, input int n);
      bus.RX_IN = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_vec(input vec_t v);
      ev_t e;
      int  fall;
      int  sel;
      fall    = cyc + 1;
      e.cyc   = fall + v.lat;
      e.dv    = v.dv;
      e.pe    = v.perr;
      e.se    = v.serr;
      e.pdata = v.pdata;
      exp_q.push_back(e);
      if (v.dv) last_good = v.d;
      bus.Prescale = 6'(v.p);
      bus.PAR_EN   = v.pe;
      bus.PAR_TYP  = v.pt;
      drive(1'b0, v.p);
      // Configuration must be ignored once the frame has started.
      if (v.scr) begin
         sel          = $urandom_range(0, 2);
         bus.Prescale = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : 6'd32;
         bus.PAR_EN   = 1'($urandom_range(0, 1));
         bus.PAR_TYP  = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++) begin
         if (v.noise) begin
            drive(v.d[i], v.p / 2 + 1);
            drive(~v.d[i], 1);
            drive(v.d[i], v.p - v.p / 2 - 2);
         end else begin
            drive(v.d[i], v.p);
         end
      end
      if (v.pe) drive(par_bit_for(v.d, v.pt) ^ v.flip, v.p);
      drive(v.stop, v.p);
      drive(1'b1, v.gap);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (bus.data_valid || bus.par_err || bus.stp_err) begin
         strobe_cnt++;
         $display("rx event cyc=%0d data_valid=%0b par_err=%0b stp_err=%0b P_DATA=%02h",
                  cyc, bus.data_valid, bus.par_err, bus.stp_err, bus.P_DATA);
         check("strobe_expected", int'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("data_valid", int'(bus.data_valid), int'(e.dv));
            check("par_err", int'(bus.par_err), int'(e.pe));
            check("stp_err", int'(bus.stp_err), int'(e.se));
            check("P_DATA", int'(bus.P_DATA), int'(e.pdata));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         s0;
      int         w;
      logic [7:0] d44;
      vec_t       v;

      bus.RX_IN    = 1'b1;
      bus.PAR_EN   = 1'b0;
      bus.PAR_TYP  = 1'b0;
      bus.Prescale = 6'd8;

      // Directed frames: p, pe, pt, data, flip, stop, noise, scr, gap, dv, perr, serr, pdata, lat
      vecs[0] = '{8,  1, 0, 8'hA5, 0, 1, 0, 0, 4,  1, 0, 0, 8'hA5, 89};
      vecs[1] = '{16, 1, 1, 8'h3C, 0, 1, 0, 0, 4,  1, 0, 0, 8'h3C, 173};
      vecs[2] = '{16, 1, 1, 8'h3C, 1, 1, 0, 0, 4,  0, 1, 0, 8'h3C, 173};
      vecs[3] = '{32, 0, 0, 8'h00, 0, 0, 0, 0, 80, 0, 0, 1, 8'h3C, 309};
      vecs[4] = '{32, 0, 0, 8'h7E, 0, 1, 0, 0, 4,  1, 0, 0, 8'h7E, 309};
      vecs[5] = '{8,  0, 0, 8'h96, 0, 1, 1, 0, 4,  1, 0, 0, 8'h96, 81};
      vecs[6] = '{8,  1, 0, 8'hF0, 1, 0, 0, 0, 80, 0, 1, 1, 8'h96, 89};
      vecs[7] = '{16, 1, 0, 8'hFF, 0, 1, 0, 0, 4,  1, 0, 0, 8'hFF, 173};

      repeat (3) @(posedge clk);
      #1;
      check("reset_P_DATA", int'(bus.P_DATA), 0);
      check("reset_data_valid", int'(bus.data_valid), 0);
      check("reset_par_err", int'(bus.par_err), 0);
      check("reset_stp_err", int'(bus.stp_err), 0);
      rst_n = 1'b1;
      drive(1'b1, 4);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Short low glitch: start bit votes 1, receiver must drop back to idle silently.
      s0           = strobe_cnt;
      bus.Prescale = 6'd16;
      bus.PAR_EN   = 1'b0;
      drive(1'b0, 3);
      drive(1'b1, 48);
      check("glitch_no_strobe", strobe_cnt - s0, 0);
      run_vec(mk(16, 0, 0, 8'h55, 0, 1, 0, 0, 4));

      // Back-to-back frames, then reset in the middle of a fourth one.
      run_vec(mk(8, 0, 0, 8'h11, 0, 1, 0, 0, 0));
      run_vec(mk(8, 0, 0, 8'h22, 0, 1, 0, 0, 0));
      run_vec(mk(8, 0, 0, 8'h33, 0, 1, 0, 0, 0));
      d44          = 8'h44;
      bus.Prescale = 6'd8;
      bus.PAR_EN   = 1'b0;
      drive(1'b0, 8);
      for (int i = 0; i < 4; i++) drive(d44[i], 8);
      #3 rst_n = 1'b0;
      #2;
      check("midrst_P_DATA", int'(bus.P_DATA), 0);
      check("midrst_data_valid", int'(bus.data_valid), 0);
      check("midrst_par_err", int'(bus.par_err), 0);
      check("midrst_stp_err", int'(bus.stp_err), 0);
      bus.RX_IN = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      last_good = 8'h00;
      drive(1'b1, 16);
      check("after_rst_P_DATA", int'(bus.P_DATA), 0);
      run_vec(mk(8, 0, 0, 8'h44, 0, 1, 0, 0, 4));

      // Random frames against the frame-level model.
      for (int k = 0; k < 30; k++) begin
         int sel;
         bit stop;
         sel  = $urandom_range(0, 2);
         stop = ($urandom_range(0, 7) != 0);
         v = mk((sel == 0) ? 8 : (sel == 1) ? 16 : 32,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), stop,
                1'($urandom_range(0, 1)), stop && ($urandom_range(0, 1) == 1),
                stop ? $urandom_range(0, 4) : 80);
         run_vec(v);
      end

      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(posedge clk);
         w++;
      end
      #1;
      check("pending_strobes", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
